// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receives asynchronous serial frames (start, DATA_BITS data bits LSB first,
// optional parity, one or two stop bits) and queues good words in a small
// first-word-fall-through FIFO. Bad words are dropped and flagged through
// sticky error outputs.
//
// Ports:
//   clock_i          sole clock, rising edge
//   reset_n_i        synchronous active-low reset
//   serial_i         asynchronous serial line, idle high
//   clock_divider_i  clocks per bit period (values below 2 act as 2)
//   parity_bit_i     1 = a parity bit follows the data bits
//   parity_even_i    1 = even parity, 0 = odd parity
//   two_stop_i       1 = two stop bits are checked
//   read_i           pop the head word (ignored while empty)
//   clear_errors_i   clear the sticky error flags
//   data_o           head word, 0 while empty
//   valid_o          FIFO not empty
//   fill_o           FIFO occupancy
//   parity_error_o   sticky: word dropped for bad parity
//   framing_error_o  sticky: word dropped for a low stop bit
//   overrun_o        sticky: word dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          serial_i,
  input  logic [DIVIDER_WIDTH-1:0]      clock_divider_i,
  input  logic                          parity_bit_i,
  input  logic                          parity_even_i,
  input  logic                          two_stop_i,
  input  logic                          read_i,
  input  logic                          clear_errors_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o,
  output logic                          parity_error_o,
  output logic                          framing_error_o,
  output logic                          overrun_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  // Synchroniser and edge-detect copy; all idle high.
  logic sync_q, rx_s, rx_d;

  logic [2:0]               state;
  logic [DIVIDER_WIDTH-1:0] cnt;
  logic [DIVIDER_WIDTH-1:0] div_q;
  logic [BIT_W-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]     shift_q;
  logic                     par_en_q, par_even_q, two_stop_q;
  logic                     par_q, stop1_ok_q;

  // Frame outcome, registered so the FIFO and flags react one clock after
  // the final stop sample.
  logic                     push_q, par_evt_q, frm_evt_q;
  logic [DATA_BITS-1:0]     push_word_q;

  logic [DATA_BITS-1:0]     mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]        wr_ptr, rd_ptr;
  logic [ADDR_W:0]          count;

  logic [DIVIDER_WIDTH-1:0] div_in;
  logic start_edge, bit_tick, frame_end, stop_ok, parity_bad;
  logic full, pop, do_push, overrun_evt;

  assign div_in     = (clock_divider_i < DIVIDER_WIDTH'(2)) ? DIVIDER_WIDTH'(2) : clock_divider_i;
  assign start_edge = rx_d && !rx_s;
  assign bit_tick   = (cnt == '0);
  assign frame_end  = bit_tick && ((state == STOP1 && !two_stop_q) || state == STOP2);
  // In STOP2 the first stop bit was stored; in STOP1 only the current sample counts.
  assign stop_ok    = rx_s && (state == STOP1 || stop1_ok_q);
  // Data XOR parity must be 0 for even and 1 for odd, so it is bad when it equals par_even.
  assign parity_bad = par_en_q && ((^shift_q ^ par_q) == par_even_q);

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= serial_i;
      rx_s   <= sync_q;
      rx_d   <= rx_s;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      cnt         <= '0;
      div_q       <= DIVIDER_WIDTH'(2);
      bit_cnt     <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      two_stop_q  <= 1'b0;
      par_q       <= 1'b0;
      stop1_ok_q  <= 1'b0;
      push_q      <= 1'b0;
      par_evt_q   <= 1'b0;
      frm_evt_q   <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q    <= 1'b0;
      par_evt_q <= 1'b0;
      frm_evt_q <= 1'b0;
      if (state == IDLE) begin
        if (start_edge) begin
          // Frame settings are frozen here; later input changes wait for the next frame.
          div_q      <= div_in;
          cnt        <= (div_in >> 1) - 1'b1;
          par_en_q   <= parity_bit_i;
          par_even_q <= parity_even_i;
          two_stop_q <= two_stop_i;
          bit_cnt    <= '0;
          state      <= START;
        end
      end else begin
        cnt <= bit_tick ? div_q - 1'b1 : cnt - 1'b1;
        if (bit_tick) begin
          case (state)
            START:  state <= rx_s ? IDLE : DATA;   // high at mid-start: noise
            DATA: begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) state <= par_en_q ? PARITY : STOP1;
            end
            PARITY: begin
              par_q <= rx_s;
              state <= STOP1;
            end
            STOP1: begin
              stop1_ok_q <= rx_s;
              state      <= two_stop_q ? STOP2 : IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
      if (frame_end) begin
        push_word_q <= shift_q;
        if (!stop_ok)        frm_evt_q <= 1'b1;
        else if (parity_bad) par_evt_q <= 1'b1;
        else                 push_q    <= 1'b1;
      end
    end
  end

  assign full        = (count == FULL_CNT);
  assign pop         = read_i && (count != '0);
  assign do_push     = push_q && (!full || pop);
  assign overrun_evt = push_q && full && !pop;

  // NOTE: the storage array has no reset; stale entries are never visible
  // because data_o is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge clock_i) begin
    if (do_push && reset_n_i) mem[wr_ptr] <= push_word_q;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error event outranks a simultaneous clear.
      if (par_evt_q)           parity_error_o  <= 1'b1;
      else if (clear_errors_i) parity_error_o  <= 1'b0;
      if (frm_evt_q)           framing_error_o <= 1'b1;
      else if (clear_errors_i) framing_error_o <= 1'b0;
      if (overrun_evt)         overrun_o       <= 1'b1;
      else if (clear_errors_i) overrun_o       <= 1'b0;
    end
  end

  assign valid_o = (count != '0);
  assign fill_o  = count;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised successor to the team's single-byte UART receiver. Deserialises an asynchronous serial line into words of configurable width with optional parity and one or two stop bits. Received words go into an internal first-word-fall-through FIFO, so the host may drain bursts instead of clearing a ready flag after every word. It sits between the pad-side `serial_i` and the host register/bus logic, and reports sticky parity, framing and overrun errors.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..8, sent LSB first.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥ 2.
- `DIVIDER_WIDTH`, 16: width of `clock_divider_i`.

- `clock_i`  in  1  sole clock; all logic on its rising edge.
- `reset_n_i`  in  1  reset, synchronous, active-low.
- `serial_i`  in  1  asynchronous serial line, idle high.
- `clock_divider_i`  in  DIVIDER_WIDTH  clocks per bit period.
- `parity_bit_i`  in  1  1 = a parity bit follows the data bits.
- `parity_even_i`  in  1  1 = even parity, 0 = odd parity.
- `two_stop_i`  in  1  1 = two stop bits are checked.
- `read_i`  in  1  pops the head word when `valid_o` = 1.
- `clear_errors_i`  in  1  clears all sticky error flags.
- `data_o`  out  DATA_BITS  FIFO head word; 0 when the FIFO is empty.
- `valid_o`  out  1  FIFO not empty.
- `fill_o`  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `parity_error_o`  out  1  sticky: a word was dropped for bad parity.
- `framing_error_o`  out  1  sticky: a word was dropped for a low stop bit.
- `overrun_o`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- `serial_i` passes through a 2-flop synchroniser, reset to 1, giving `rx_s`. A registered copy `rx_d`, also reset to 1, is used for falling-edge detection.
- Per-frame latches, captured at start detection:
  - `clock_divider_i` → `div`. Values below 2 are treated as 2.
  - `parity_bit_i`, `parity_even_i` and `two_stop_i`.
  - Input changes mid-frame have no effect on the current frame.
- State machine: IDLE → START → DATA → PARITY (skipped if no parity) → STOP1 → STOP2 (only if `two_stop_i`) → IDLE.
  - IDLE: a falling edge (`rx_d` = 1, `rx_s` = 0) loads the bit counter and enters START.
  - START: after floor(div/2) clocks, sample `rx_s`. If 1, this was an invalid start bit (noise): abort to IDLE with no flags and no push. If 0, proceed.
  - DATA, PARITY, STOP1, STOP2: each bit is sampled exactly `div` clocks after the previous sample. Data is shifted in LSB first.
  - Parity check: the XOR of the data bits and the parity bit must be 0 for even parity and 1 for odd parity.
- End of frame, evaluated at the final stop-bit sample:
  - Any stop sample low → drop the word, set `framing_error_o`.
  - Otherwise a parity mismatch → drop the word, set `parity_error_o`.
  - Otherwise push the word.
  - In all cases return to IDLE in the same cycle, so a start edge during the back half of the stop bit is caught.
- FIFO behaviour:
  - Push when full → word dropped, `overrun_o` set, contents unchanged.
  - Push and pop in the same cycle when full → both take effect, `fill_o` unchanged.
  - `read_i` while empty is ignored.
- `clear_errors_i` clears all three error flags. If it coincides with a new error event, the event wins and the flag stays 1.

## Timing
- Reset (`reset_n_i` = 0 at an edge):
  - state IDLE, FIFO empty;
  - `data_o` = 0, `valid_o` = 0, `fill_o` = 0, all error flags 0;
  - synchroniser flops = 1.
- A reset mid-frame abandons the frame and pushes nothing.
- Detection latency: 2 clocks from `serial_i` to `rx_s`, plus 1 clock for edge detection.
- Sample point: bit n (start = 0) is sampled floor(div/2) + n·div clocks after the detection cycle.
- Push latency: `valid_o`, `fill_o` and `data_o` update on the clock after the final stop sample.
- Pop latency: on a pop, the next word (or 0 if the FIFO empties) appears on `data_o` the following clock.

## Test plan
- Valid frame: div = 4, 8N1, send 0x55, 1 stop bit → `valid_o` = 1, `data_o` = 0x55, `fill_o` = 1, no errors. Pulse `read_i` → `valid_o` = 0.
- Invalid start bit: a 1-clock low glitch on `serial_i`, then a 0x55 frame → exactly one word, 0x55, no errors.
- Parity:
  - Even parity, send 0xA3 with parity bit 0 → received, no error.
  - Same frame with parity bit 1 → nothing pushed, `parity_error_o` = 1.
  - Pulse `clear_errors_i` → `parity_error_o` = 0.
- Framing: two_stop = 1, send 0x3C with the second stop bit low → nothing pushed, `framing_error_o` = 1.
- Overrun: FIFO_DEPTH = 4, send 0x01..0x05 back-to-back with no reads → `fill_o` = 4 and `overrun_o` = 1. Reads return 0x01, 0x02, 0x03, 0x04 in order.
- Reset mid-frame and divider latch:
  - Assert `reset_n_i` = 0 for 1 clock during data bit 3 → all outputs 0; the next full frame 0x7E is received correctly.
  - Change `clock_divider_i` from 4 to 8 mid-frame → the current frame still decodes at div = 4.
